// File: rtl/tlc_pkg.sv
// Shared types and constants for the highway/farm-road traffic light controller.
package tlc_pkg;

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  // Binary state encoding; the values are fixed so the state register can be
  // observed directly when debugging.
  typedef enum logic [1:0] {
    S_HG = 2'd0,
    S_HY = 2'd1,
    S_FG = 2'd2,
    S_FY = 2'd3
  } tlc_state_e;

  typedef struct packed {
    logic hg;
    logic hy;
    logic hr;
    logic fg;
    logic fy;
    logic fr;
  } tlc_lamps_t;

  // Moore lamp decode. Every state lights exactly one lamp per road.
  function automatic tlc_lamps_t lamp_decode(input tlc_state_e s);
    tlc_lamps_t l;
    l = '0;
    case (s)
      S_HG: begin l.hg = 1'b1; l.fr = 1'b1; end
      S_HY: begin l.hy = 1'b1; l.fr = 1'b1; end
      S_FG: begin l.hr = 1'b1; l.fg = 1'b1; end
      default: begin l.hr = 1'b1; l.fy = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_timer.sv
// State-duration timer: counts cycles spent in the current state, cleared on
// every state transition, saturating so a long idle period never wraps.
module tlc_timer
  import tlc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  output logic [TIMER_W-1:0] count_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear wins, otherwise increment until the top value.
  always_comb begin
    if (clr_i) begin
      count_d = '0;
    end else if (count_q == TIMER_MAX) begin
      count_d = count_q;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tlc_top.sv
// Traffic light controller top: state FSM, state-duration timer and lamp drive.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   HG    | highway green, farm red; default, held at least lvalue
//   HY    | highway yellow, farm red; exactly svalue cycles
//   FG    | highway red, farm green; until detect drops or lvalue
//   FY    | highway red, farm yellow; exactly svalue cycles
module tlc_top
  import tlc_pkg::*;
#(
  parameter int unsigned svalue = 3,
  parameter int unsigned lvalue = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic detect,
  output logic hg,
  output logic hy,
  output logic hr,
  output logic fg,
  output logic fy,
  output logic fr
);

  // Expiry thresholds: a state with duration N is left when the timer,
  // which reads 0 in the first cycle of the state, reaches N-1.
  localparam logic [TIMER_W-1:0] S_LIM = TIMER_W'(svalue - 1);
  localparam logic [TIMER_W-1:0] L_LIM = TIMER_W'(lvalue - 1);

  tlc_state_e         state_q;
  tlc_state_e         state_d;
  tlc_lamps_t         lamps_q;
  logic [TIMER_W-1:0] timer;
  logic               ts;
  logic               tl;
  logic               trans;

  tlc_timer u_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (trans),
    .count_o (timer)
  );

  assign ts = (timer >= S_LIM);
  assign tl = (timer >= L_LIM);

  // Next-state logic; detect is only sampled in HG and FG.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HG: if (detect && tl)  state_d = S_HY;
      S_HY: if (ts)            state_d = S_FG;
      S_FG: if (!detect || tl) state_d = S_FY;
      default: if (ts)         state_d = S_HG;
    endcase
  end

  assign trans = (state_d != state_q);

  // State and lamp registers. Lamps are loaded from the decode of the next
  // state, so they always equal the decode of the current state register and
  // change in the same cycle as the state; async reset forces HG lamps at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HG;
      lamps_q <= lamp_decode(S_HG);
    end else begin
      state_q <= state_d;
      lamps_q <= lamp_decode(state_d);
    end
  end

  assign hg = lamps_q.hg;
  assign hy = lamps_q.hy;
  assign hr = lamps_q.hr;
  assign fg = lamps_q.fg;
  assign fy = lamps_q.fy;
  assign fr = lamps_q.fr;

endmodule

// File: tb/tb_tlc_top.sv
// Self-checking bench for tlc_top: reference model feeding a scoreboard queue,
// a hand-derived vector table, and explicit timing/reset corner sequences.
module tb_tlc_top;

  localparam int SV = 3;
  localparam int LV = 8;

  // Lamp patterns, ordered {hg,hy,hr,fg,fy,fr}.
  localparam logic [5:0] L_HG = 6'b100001;
  localparam logic [5:0] L_HY = 6'b010001;
  localparam logic [5:0] L_FG = 6'b001100;
  localparam logic [5:0] L_FY = 6'b001010;

  typedef struct {
    logic       det;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic detect;
  logic hg, hy, hr, fg, fy, fr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  int m_state;
  int m_timer;

  tlc_top #(.svalue(SV), .lvalue(LV)) dut (
    .clk    (clk),
    .reset  (reset),
    .detect (detect),
    .hg     (hg),
    .hy     (hy),
    .hr     (hr),
    .fg     (fg),
    .fy     (fy),
    .fr     (fr)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lamps_now();
    return {hg, hy, hr, fg, fy, fr};
  endfunction

  function automatic logic [5:0] mlamps(input int s);
    case (s)
      0: return L_HG;
      1: return L_HY;
      2: return L_FG;
      default: return L_FY;
    endcase
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_inv();
    logic ok;
    ok = ($countones({hg, hy, hr}) == 1) && ($countones({fg, fy, fr}) == 1) &&
         !(hg && fg) && (hr || fr);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL invariant: got lamps %b expected safe pattern at %0t", lamps_now(), $time);
    end
  endtask

  // Reference model of one rising edge with the given detect level.
  task automatic model_edge(input logic det);
    int nxt;
    nxt = m_state;
    case (m_state)
      0: if (det && m_timer >= LV - 1) nxt = 1;
      1: if (m_timer >= SV - 1) nxt = 2;
      2: if (!det || m_timer >= LV - 1) nxt = 3;
      default: if (m_timer >= SV - 1) nxt = 0;
    endcase
    if (nxt != m_state) m_timer = 0;
    else if (m_timer < 255) m_timer = m_timer + 1;
    m_state = nxt;
  endtask

  // Drive one cycle (called at negedge) and score the result at the next negedge.
  task automatic run_cycle(input logic det, input logic [5:0] exp);
    logic [5:0] e;
    detect = det;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_int("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("lamps", lamps_now(), e);
    end
    check_inv();
  endtask

  task automatic step(input logic det);
    model_edge(det);
    run_cycle(det, mlamps(m_state));
  endtask

  task automatic tstep(input logic det, input logic [5:0] exp);
    model_edge(det);
    run_cycle(det, exp);
  endtask

  // Asynchronous reset applied mid-low-phase; lamps must go to HG before any edge.
  task automatic do_reset(input int cycles);
    #2;
    reset = 1'b1;
    #1;
    check("reset_immediate", lamps_now(), L_HG);
    check_inv();
    m_state = 0;
    m_timer = 0;
    repeat (cycles) @(negedge clk);
    check("reset_held", lamps_now(), L_HG);
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int t_hy, t_fg, t_fy, t_hg, t_hy2, cyc;
    logic [5:0] prev, cur;

    tbl[0] = '{1'b1, L_HY};
    tbl[1] = '{1'b0, L_HY};
    tbl[2] = '{1'b0, L_HY};
    tbl[3] = '{1'b0, L_FG};
    tbl[4] = '{1'b0, L_FY};
    tbl[5] = '{1'b0, L_FY};
    tbl[6] = '{1'b0, L_FY};
    tbl[7] = '{1'b0, L_HG};

    // Scenario 1: reset for 2 cycles then idle; outputs valid before any edge.
    reset  = 1'b1;
    detect = 1'b0;
    m_state = 0;
    m_timer = 0;
    #1;
    check("reset_t0", lamps_now(), L_HG);
    check_inv();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tstep(1'b0, L_HG);
    end

    // Scenario 2: continuous detect from cycle 0 after reset.
    do_reset(2);
    t_hy = -1; t_fg = -1; t_fy = -1; t_hg = -1; t_hy2 = -1;
    prev = lamps_now();
    for (int i = 0; i < 34; i++) begin
      step(1'b1);
      cyc = i + 1;
      cur = lamps_now();
      if (cur != prev) begin
        if (cur == L_HY && t_hy < 0) t_hy = cyc;
        else if (cur == L_HY && t_hy2 < 0) t_hy2 = cyc;
        if (cur == L_FG && t_fg < 0) t_fg = cyc;
        if (cur == L_FY && t_fy < 0) t_fy = cyc;
        if (cur == L_HG && t_hg < 0) t_hg = cyc;
      end
      prev = cur;
    end
    check_int("cycle_hy", t_hy, 8);
    check_int("cycle_fg", t_fg, 11);
    check_int("cycle_fy", t_fy, 19);
    check_int("cycle_hg", t_hg, 22);
    check_int("cycle_hy_period", t_hy2, 30);

    // Scenario 3: long HG idle, then one-cycle detect pulse (table-driven).
    do_reset(2);
    for (int i = 0; i < 20; i++) tstep(1'b0, L_HG);
    foreach (tbl[i]) tstep(tbl[i].det, tbl[i].exp);

    // Detect before tl is not latched.
    do_reset(2);
    for (int i = 0; i < 3; i++) tstep(1'b1, L_HG);
    for (int i = 0; i < 10; i++) tstep(1'b0, L_HG);

    // Scenario 4: detect dropped after 3 FG cycles.
    do_reset(2);
    for (int i = 0; i < 11; i++) step(1'b1);
    check("fg_entered", lamps_now(), L_FG);
    tstep(1'b1, L_FG);
    tstep(1'b1, L_FG);
    tstep(1'b0, L_FY);
    tstep(1'b1, L_FY);
    tstep(1'b1, L_FY);
    tstep(1'b0, L_HG);

    // Scenario 5: async reset mid-FG, then HY only after a full lvalue.
    do_reset(2);
    for (int i = 0; i < 13; i++) step(1'b1);
    check("fg_before_reset", lamps_now(), L_FG);
    do_reset(1);
    t_hy = -1;
    for (int i = 0; i < 40 && t_hy < 0; i++) begin
      step(1'b1);
      if (lamps_now() == L_HY) t_hy = i + 1;
    end
    check_int("hy_after_reset", t_hy, LV);

    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
